// File: rtl/sequencer_pkg.sv
// sequencer_pkg: note codes and the note-cycling rule shared by the sequencer track.
// Note codes run OFF -> LOW_C .. HIGH_C and wrap back to OFF.
package sequencer_pkg;

    typedef enum logic [3:0] {
        OFF     = 4'd0,
        LOW_C   = 4'd1,
        LOW_CS  = 4'd2,
        LOW_D   = 4'd3,
        LOW_DS  = 4'd4,
        LOW_E   = 4'd5,
        LOW_F   = 4'd6,
        LOW_FS  = 4'd7,
        LOW_G   = 4'd8,
        LOW_GS  = 4'd9,
        LOW_A   = 4'd10,
        LOW_AS  = 4'd11,
        LOW_B   = 4'd12,
        HIGH_C  = 4'd13
    } note_t;

    localparam logic [3:0] NOTE_MAX = 4'd13;

    // Next note for a toggle: step up one semitone, wrap HIGH_C to OFF.
    // Codes above NOTE_MAX cannot be written, but if one ever appears it
    // is treated like the top of the range so the step recovers to OFF.
    function automatic note_t next_note(input note_t cur);
        note_t nxt;
        if (cur >= NOTE_MAX) begin
            nxt = OFF;
        end else begin
            nxt = note_t'(cur + 4'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sequencer_step_mem.sv
// sequencer_step_mem: NUM_STEPS x 4-bit note register file.
// One write port, a synchronous clear of every step, and one
// asynchronous read port. Out-of-range read indices return OFF.
module sequencer_step_mem
    import sequencer_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int IDX_W     = $clog2(NUM_STEPS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [3:0]       rd_data
);

    logic [3:0] mem_r [NUM_STEPS];
    logic       wr_ok_s;
    logic       rd_ok_s;

    assign wr_ok_s = (32'(wr_idx) < 32'(NUM_STEPS));
    assign rd_ok_s = (32'(rd_idx) < 32'(NUM_STEPS));

    // Step storage: reset and clear empty every step, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mem_r <= '{default: 4'd0};
        end else if (clr) begin
            mem_r <= '{default: 4'd0};
        end else if (we && wr_ok_s) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Asynchronous read; indices past the last step read as OFF.
    always_comb begin
        rd_data = 4'd0;
        if (rd_ok_s) begin
            rd_data = mem_r[rd_idx];
        end else begin
            rd_data = 4'd0;
        end
    end

endmodule

// File: rtl/sequencer_track.sv
// sequencer_track: multi-step note track for sequencer mode.
// Stores one note per step, edits them through a cursor, and plays the
// note addressed by the measure counter's beat with one cycle of latency.
// Optional feature macro: SEQ_GATE_EN -- when defined, a per-beat gate
// counter limits each note to GATE_CYCLES clocks; when undefined, notes
// sound for the whole beat and GATE_CYCLES is ignored.
module sequencer_track
    import sequencer_pkg::*;
#(
    parameter int NUM_STEPS   = 8,
    parameter int BEAT_W      = 4,
    parameter int GATE_CYCLES = 2500
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         sequencer_on,
    input  logic                         toggle,
    input  logic                         step_next,
    input  logic                         clear,
    input  logic [BEAT_W-1:0]            beat,
    input  logic                         beat_strobe,
    output logic [$clog2(NUM_STEPS)-1:0] edit_step,
    output logic [3:0]                   note_out,
    output logic                         gate
);

    localparam int               IDX_W     = $clog2(NUM_STEPS);
    localparam logic [IDX_W-1:0] STEP_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] STEP_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] STEP_LAST = IDX_W'(NUM_STEPS - 1);

    // Parameter sanity: catch impossible configurations at elaboration.
    generate
        if ((NUM_STEPS < 2) || (NUM_STEPS > 16)) begin : g_bad_steps
            $error("sequencer_track: NUM_STEPS must lie in 2..16");
        end
        if ((2 ** BEAT_W) < NUM_STEPS) begin : g_bad_beat
            $error("sequencer_track: BEAT_W too narrow to address every step");
        end
        if (GATE_CYCLES < 1) begin : g_bad_gate
            $error("sequencer_track: GATE_CYCLES must be at least 1");
        end
    endgenerate

    logic [IDX_W-1:0] edit_step_r;
    logic [IDX_W-1:0] cursor_nxt_s;
    logic [3:0]       note_out_r;
    logic [3:0]       note_nxt_s;
    logic [3:0]       play_s;

    logic             edit_clr_s;
    logic             edit_tog_s;
    logic             edit_stp_s;
    logic             beat_ok_s;

    logic [IDX_W-1:0] rd_idx_s;
    logic [3:0]       rd_data_s;
    logic [3:0]       preview_s;

    // Edits only count in sequencer mode; clear overrides toggle and step_next.
    // toggle and step_next together edit the old cursor, then advance it.
    assign edit_clr_s = sequencer_on & clear;
    assign edit_tog_s = sequencer_on & toggle & ~clear;
    assign edit_stp_s = sequencer_on & step_next & ~clear;

    assign beat_ok_s  = (32'(beat) < 32'(NUM_STEPS));

    // A single read port is shared: a toggle needs the note under the
    // cursor (and that edited value is what plays next cycle), otherwise
    // playback needs the note under the beat.
    assign rd_idx_s   = edit_tog_s ? edit_step_r : beat[IDX_W-1:0];
    assign preview_s  = next_note(note_t'(rd_data_s));

    sequencer_step_mem #(
        .NUM_STEPS (NUM_STEPS),
        .IDX_W     (IDX_W)
    ) u_step_mem (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (edit_clr_s),
        .we      (edit_tog_s),
        .wr_idx  (edit_step_r),
        .wr_data (preview_s),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s)
    );

    // Edit cursor next value: clear homes it, step_next advances with wrap.
    always_comb begin
        cursor_nxt_s = edit_step_r;
        if (edit_clr_s) begin
            cursor_nxt_s = STEP_ZERO;
        end else if (edit_stp_s) begin
            if (edit_step_r == STEP_LAST) begin
                cursor_nxt_s = STEP_ZERO;
            end else begin
                cursor_nxt_s = edit_step_r + STEP_ONE;
            end
        end else begin
            cursor_nxt_s = edit_step_r;
        end
    end

    // Playback value: silent in piano mode and on clear, the edited note
    // right after a toggle, otherwise the step addressed by beat.
    always_comb begin
        play_s = 4'd0;
        if (!sequencer_on) begin
            play_s = 4'd0;
        end else if (edit_clr_s) begin
            play_s = 4'd0;
        end else if (edit_tog_s) begin
            play_s = preview_s;
        end else if (beat_ok_s) begin
            play_s = rd_data_s;
        end else begin
            play_s = 4'd0;
        end
    end

`ifdef SEQ_GATE_EN
    localparam int               CNT_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] gate_cnt_r;
    logic [CNT_W-1:0] gate_cnt_nxt_s;
    logic             gate_act_r;
    logic             gate_act_nxt_s;

    // Gate counter next state. The active flag covers the final count of
    // zero, so a load of GATE_CYCLES-1 keeps the gate open GATE_CYCLES clocks.
    // A strobe or preview of a sounding note (re)loads; one of OFF closes it.
    always_comb begin
        gate_cnt_nxt_s = gate_cnt_r;
        gate_act_nxt_s = gate_act_r;
        if (!sequencer_on || edit_clr_s) begin
            gate_cnt_nxt_s = CNT_ZERO;
            gate_act_nxt_s = 1'b0;
        end else if (edit_tog_s || beat_strobe) begin
            if (play_s != 4'd0) begin
                gate_cnt_nxt_s = CNT_LOAD;
                gate_act_nxt_s = 1'b1;
            end else begin
                gate_cnt_nxt_s = CNT_ZERO;
                gate_act_nxt_s = 1'b0;
            end
        end else if (gate_act_r) begin
            if (gate_cnt_r == CNT_ZERO) begin
                gate_cnt_nxt_s = CNT_ZERO;
                gate_act_nxt_s = 1'b0;
            end else begin
                gate_cnt_nxt_s = gate_cnt_r - CNT_ONE;
                gate_act_nxt_s = 1'b1;
            end
        end else begin
            gate_cnt_nxt_s = gate_cnt_r;
            gate_act_nxt_s = gate_act_r;
        end
    end

    // Gate counter registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            gate_cnt_r <= CNT_ZERO;
            gate_act_r <= 1'b0;
        end else begin
            gate_cnt_r <= gate_cnt_nxt_s;
            gate_act_r <= gate_act_nxt_s;
        end
    end

    // A closed gate silences the note so note_out and gate always agree.
    assign note_nxt_s = gate_act_nxt_s ? play_s : 4'd0;
    assign gate       = gate_act_r;
`else
    // Without the gate counter the strobe has no role; notes hold for the beat.
    logic unused_strobe_s;
    assign unused_strobe_s = beat_strobe;
    assign note_nxt_s      = play_s;
    assign gate            = (note_out_r != 4'd0);
`endif

    // Cursor and playback registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            edit_step_r <= STEP_ZERO;
            note_out_r  <= 4'd0;
        end else begin
            edit_step_r <= cursor_nxt_s;
            note_out_r  <= note_nxt_s;
        end
    end

    assign edit_step = edit_step_r;
    assign note_out  = note_out_r;

endmodule

// File: tb/tb_sequencer_track.sv
// tb_sequencer_track: scoreboard bench for sequencer_track.
// Stimulus pushes hand-computed expectations tagged with the cycle in
// which they must appear; a negedge monitor pops and compares them.
module tb_sequencer_track;

    localparam int NUM_STEPS   = 8;
    localparam int BEAT_W      = 4;
    localparam int GATE_CYCLES = 4;

    logic       clk          = 1'b0;
    logic       n_rst        = 1'b0;
    logic       sequencer_on = 1'b0;
    logic       toggle       = 1'b0;
    logic       step_next    = 1'b0;
    logic       clear        = 1'b0;
    logic       beat_strobe  = 1'b0;
    logic [3:0] beat         = 4'd0;
    logic [2:0] edit_step;
    logic [3:0] note_out;
    logic       gate;

    sequencer_track #(
        .NUM_STEPS   (NUM_STEPS),
        .BEAT_W      (BEAT_W),
        .GATE_CYCLES (GATE_CYCLES)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sequencer_on (sequencer_on),
        .toggle       (toggle),
        .step_next    (step_next),
        .clear        (clear),
        .beat         (beat),
        .beat_strobe  (beat_strobe),
        .edit_step    (edit_step),
        .note_out     (note_out),
        .gate         (gate)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int test_no  = 0;
    int sub_no   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         id;
        logic [3:0] note;
        logic       gate;
        logic [2:0] es;
    } exp_t;

    exp_t exp_q[$];

    // Expect note/gate/cursor right after the coming clock edge.
    task automatic expect_full(input logic [3:0] n, input logic g, input logic [2:0] es);
        exp_t e;
        e.cyc  = cyc + 1;
        e.id   = test_no * 1000 + sub_no;
        e.note = n;
        e.gate = g;
        e.es   = es;
        sub_no++;
        exp_q.push_back(e);
    endtask

    // Whole-beat gating: gate is high exactly when a note is playing.
    task automatic expect_out(input logic [3:0] n, input logic [2:0] es);
        expect_full(n, (n != 4'd0), es);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        toggle      = 1'b0;
        step_next   = 1'b0;
        clear       = 1'b0;
        beat_strobe = 1'b0;
    endtask

    task automatic new_test(input int t);
        test_no = t;
        sub_no  = 0;
    endtask

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc || note_out !== e.note || gate !== e.gate || edit_step !== e.es) begin
                failures++;
                $display("FAIL out[t%0d.%0d] cyc=%0d got note=%0d gate=%0b step=%0d, expected note=%0d gate=%0b step=%0d (due cyc %0d)",
                         e.id / 1000, e.id % 1000, cyc, note_out, gate, edit_step, e.note, e.gate, e.es, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: everything OFF, cursor home.
        new_test(0);
        n_rst = 1'b0; sequencer_on = 1'b1; beat = 4'd15;
        tick();
        expect_full(4'd0, 1'b0, 3'd0); tick();
        n_rst = 1'b1;
        expect_full(4'd0, 1'b0, 3'd0); tick();

`ifndef SEQ_GATE_EN
        // 1: three toggles at step 0, preview each time, then replay D (3).
        new_test(1);
        for (int k = 1; k <= 3; k++) begin
            toggle = 1'b1; expect_out(4'(k), 3'd0); tick();
            expect_out(4'd0, 3'd0); tick();
        end
        beat = 4'd0; expect_out(4'd3, 3'd0); tick();

        // 2: wrap rule at step 1: 14 toggles back to OFF, 13 more to HIGH_C.
        new_test(2);
        step_next = 1'b1; expect_out(4'd3, 3'd1); tick();
        beat = 4'd15;
        for (int k = 1; k <= 13; k++) begin
            toggle = 1'b1; expect_out(4'(k), 3'd1); tick();
        end
        toggle = 1'b1; expect_out(4'd0, 3'd1); tick();
        beat = 4'd1; expect_out(4'd0, 3'd1); tick();
        beat = 4'd15;
        for (int k = 1; k <= 13; k++) begin
            toggle = 1'b1; expect_out(4'(k), 3'd1); tick();
        end
        beat = 4'd1; expect_out(4'd13, 3'd1); tick();

        // 3: step 2 = E (5), beat sweep plays it only on beat 2.
        new_test(3);
        beat = 4'd15;
        clear = 1'b1; expect_out(4'd0, 3'd0); tick();
        step_next = 1'b1; expect_out(4'd0, 3'd1); tick();
        step_next = 1'b1; expect_out(4'd0, 3'd2); tick();
        for (int k = 1; k <= 5; k++) begin
            toggle = 1'b1; expect_out(4'(k), 3'd2); tick();
        end
        for (int b = 0; b < 8; b++) begin
            beat = 4'(b); expect_out((b == 2) ? 4'd5 : 4'd0, 3'd2); tick();
        end
        beat = 4'd9; expect_out(4'd0, 3'd2); tick();
        beat = 4'd2; expect_out(4'd5, 3'd2); tick();

        // 4: step 5 = C# (2); piano mode silences and ignores edits.
        new_test(4);
        beat = 4'd15;
        for (int k = 3; k <= 5; k++) begin
            step_next = 1'b1; expect_out(4'd0, 3'(k)); tick();
        end
        toggle = 1'b1; expect_out(4'd1, 3'd5); tick();
        toggle = 1'b1; expect_out(4'd2, 3'd5); tick();
        beat = 4'd2; sequencer_on = 1'b0; expect_out(4'd0, 3'd5); tick();
        for (int i = 0; i < 100; i++) begin
            beat      = 4'(i % 8);
            toggle    = ((i % 10) == 3);
            step_next = ((i % 10) == 6);
            clear     = (i == 50);
            expect_out(4'd0, 3'd5); tick();
        end
        sequencer_on = 1'b1;
        beat = 4'd2; expect_out(4'd5, 3'd5); tick();
        beat = 4'd5; expect_out(4'd2, 3'd5); tick();
        beat = 4'd3; expect_out(4'd0, 3'd5); tick();

        // 5: clear wins over toggle+step_next; toggle+step_next at step 7 wraps.
        new_test(5);
        beat = 4'd2; clear = 1'b1; toggle = 1'b1; step_next = 1'b1;
        expect_out(4'd0, 3'd0); tick();
        beat = 4'd5; expect_out(4'd0, 3'd0); tick();
        beat = 4'd2; expect_out(4'd0, 3'd0); tick();
        beat = 4'd15;
        for (int k = 1; k <= 7; k++) begin
            step_next = 1'b1; expect_out(4'd0, 3'(k)); tick();
        end
        toggle = 1'b1; step_next = 1'b1; expect_out(4'd1, 3'd0); tick();
        beat = 4'd7; expect_out(4'd1, 3'd0); tick();
        beat = 4'd6; expect_out(4'd0, 3'd0); tick();
`else
        // 6: gate length 4, retrigger, reset mid-count.
        new_test(6);
        toggle = 1'b1; expect_full(4'd1, 1'b1, 3'd0); tick();
        toggle = 1'b1; expect_full(4'd2, 1'b1, 3'd0); tick();
        for (int k = 0; k < 3; k++) begin
            expect_full(4'd0, 1'b1, 3'd0); tick();
        end
        expect_full(4'd0, 1'b0, 3'd0); tick();
        beat = 4'd0; beat_strobe = 1'b1; expect_full(4'd2, 1'b1, 3'd0); tick();
        for (int k = 0; k < 3; k++) begin
            expect_full(4'd2, 1'b1, 3'd0); tick();
        end
        expect_full(4'd0, 1'b0, 3'd0); tick();
        expect_full(4'd0, 1'b0, 3'd0); tick();
        beat_strobe = 1'b1; expect_full(4'd2, 1'b1, 3'd0); tick();
        expect_full(4'd2, 1'b1, 3'd0); tick();
        beat_strobe = 1'b1; expect_full(4'd2, 1'b1, 3'd0); tick();
        for (int k = 0; k < 3; k++) begin
            expect_full(4'd2, 1'b1, 3'd0); tick();
        end
        expect_full(4'd0, 1'b0, 3'd0); tick();
        beat_strobe = 1'b1; expect_full(4'd2, 1'b1, 3'd0); tick();
        expect_full(4'd2, 1'b1, 3'd0); tick();
        n_rst = 1'b0; expect_full(4'd0, 1'b0, 3'd0); tick();
        n_rst = 1'b1; expect_full(4'd0, 1'b0, 3'd0); tick();
        beat_strobe = 1'b1; expect_full(4'd0, 1'b0, 3'd0); tick();
`endif

        tick();
        tick();
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations never compared, expected 0", exp_q.size());
            failures += exp_q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
